// File: rtl/bsg_barrier_pkg.sv
// Shared constants for the barrier network: direction indices and
// the root encoding of the destination select.
package bsg_barrier_pkg;

    localparam int DIR_P  = 0;
    localparam int DIR_W  = 1;
    localparam int DIR_E  = 2;
    localparam int DIR_N  = 3;
    localparam int DIR_S  = 4;
    localparam int DIR_RW = 5;
    localparam int DIR_RE = 6;

    // A destination equal to the direction count marks the root.
    function automatic int root_dir(int dirs);
        return dirs;
    endfunction

endpackage

// File: rtl/bsg_barrier_node_if.sv
// Barrier node bus: per-direction data in/out plus the quasi-static
// source mask and destination select. master = tile side, slave = node.
interface bsg_barrier_node_if #(
    parameter int dirs_p = 7
);
    localparam int lg_dirs_lp = $clog2(dirs_p + 1);

    logic [dirs_p-1:0]     data_i;
    logic [dirs_p-1:0]     data_o;
    logic [dirs_p-1:0]     src_r_i;
    logic [lg_dirs_lp-1:0] dest_r_i;

    modport master (
        output data_i,
        output src_r_i,
        output dest_r_i,
        input  data_o
    );

    modport slave (
        input  data_i,
        input  src_r_i,
        input  dest_r_i,
        output data_o
    );
endinterface

// File: rtl/barrier_dff_ar.sv
// Width-parameterised flop with asynchronous active-low clear.
// Ports: clk_i, reset_ni, d_i[width_p], q_o[width_p].
module barrier_dff_ar #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) q_o <= '0;
        else           q_o <= d_i;
    end

endmodule

// File: rtl/bsg_barrier_node.sv
// Sense-reversing single-bit barrier node: gathers child arrivals,
// forwards to parent, broadcasts the release sense back down.
// Ports: clk_i, reset_ni (async active-low), bar_if (slave: data_i,
// data_o, src_r_i, dest_r_i). Optional BSG_BARRIER_NODE_ASSERT_EN
// enables simulation-only legality checks.
module bsg_barrier_node
    import bsg_barrier_pkg::*;
#(
    parameter int dirs_p = 7
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    bsg_barrier_node_if.slave   bar_if
);

    localparam int lg_dirs_lp = $clog2(dirs_p + 1);
    localparam logic [lg_dirs_lp-1:0] root_lp =
        lg_dirs_lp'(root_dir(dirs_p));

    logic [dirs_p-1:0] data_d, data_q;
    logic              sense_d, sense_q;
    logic              gather_and, gather_or, gather_out;
    logic              is_root;
    logic              bcast_in;
    logic [dirs_p-1:0] data_o_n;

    barrier_dff_ar #(.width_p(dirs_p)) data_reg (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (data_d),
        .q_o      (data_q)
    );

    barrier_dff_ar #(.width_p(1)) sense_reg (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (sense_d),
        .q_o      (sense_q)
    );

    // Phase 0 waits for every source to rise; phase 1 holds the
    // gather until every source has dropped again.
    always_comb begin
        gather_and = &(~bar_if.src_r_i | data_q);
        gather_or  = |( bar_if.src_r_i & data_q);
        gather_out = sense_q ? gather_or : gather_and;
    end

    // Out-of-range destinations fall back to root behaviour.
    assign is_root = (bar_if.dest_r_i >= root_lp);

    always_comb begin
        bcast_in = gather_out;
        data_o_n = {dirs_p{sense_q}};
        if (!is_root) begin
            for (int i = 0; i < dirs_p; i++) begin
                if (bar_if.dest_r_i == lg_dirs_lp'(i)) begin
                    bcast_in    = data_q[i];
                    data_o_n[i] = gather_out;
                end
            end
        end
    end

    assign data_d        = bar_if.data_i;
    assign sense_d       = bcast_in;
    assign bar_if.data_o = data_o_n;

`ifdef BSG_BARRIER_NODE_ASSERT_EN
    logic [dirs_p-1:0]     src_prev_q;
    logic [lg_dirs_lp-1:0] dest_prev_q;
    logic                  idle;

    assign idle = ((&bar_if.data_i) | ~(|bar_if.data_i))
                & ((&data_q) | ~(|data_q))
                & (bar_if.data_i[0] == data_q[0])
                & (data_q[0] == sense_q);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            src_prev_q  <= '0;
            dest_prev_q <= '0;
        end else begin
            src_prev_q  <= bar_if.src_r_i;
            dest_prev_q <= bar_if.dest_r_i;
            if (bar_if.dest_r_i > root_lp)
                $error("barrier: dest_r_i out of range");
            if (!is_root && |(bar_if.src_r_i & ~data_o_n & data_o_n))
                $error("barrier: unreachable");
            if (!is_root) begin
                for (int i = 0; i < dirs_p; i++) begin
                    if (bar_if.dest_r_i == lg_dirs_lp'(i)
                        && bar_if.src_r_i[i])
                        $error("barrier: src_r_i set at dest_r_i");
                end
            end
            if (!idle && (bar_if.src_r_i != src_prev_q
                          || bar_if.dest_r_i != dest_prev_q))
                $error("barrier: config changed while busy");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_barrier_node.sv
// Directed bench for bsg_barrier_node: reset sequences by hand,
// then a table of {config, data_i, expected data_o} steps.
module tb_bsg_barrier_node;
    import bsg_barrier_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    bsg_barrier_node_if #(.dirs_p(7)) bar_if ();

    bsg_barrier_node #(.dirs_p(7)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bar_if   (bar_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] src;
        logic [2:0] dest;
        logic [6:0] din;
        logic [6:0] exp;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string nm, input logic [6:0] exp);
        n_cmp++;
        if (bar_if.data_o !== exp) begin
            n_err++;
            $display("FAIL %s: data_o got %h want %h",
                     nm, bar_if.data_o, exp);
        end
    endtask

    task automatic add(input logic [6:0] s, input logic [2:0] d,
                       input logic [6:0] di, input logic [6:0] e);
        vec_t v;
        v.src  = s;
        v.dest = d;
        v.din  = di;
        v.exp  = e;
        tv.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // leaf gather (P -> W)
        add(7'h01, 3'd1, 7'h00, 7'h00);
        add(7'h01, 3'd1, 7'h01, 7'h02);
        add(7'h01, 3'd1, 7'h01, 7'h02);
        add(7'h01, 3'd1, 7'h00, 7'h00);
        // root release and sense reversal (P,E)
        add(7'h05, 3'd7, 7'h00, 7'h00);
        add(7'h05, 3'd7, 7'h01, 7'h00);
        add(7'h05, 3'd7, 7'h01, 7'h00);
        add(7'h05, 3'd7, 7'h05, 7'h00);
        add(7'h05, 3'd7, 7'h05, 7'h7F);
        add(7'h05, 3'd7, 7'h04, 7'h7F);
        add(7'h05, 3'd7, 7'h04, 7'h7F);
        add(7'h05, 3'd7, 7'h00, 7'h7F);
        add(7'h05, 3'd7, 7'h00, 7'h00);
        add(7'h05, 3'd7, 7'h00, 7'h00);
        // non-root broadcast from N
        add(7'h01, 3'd3, 7'h00, 7'h00);
        add(7'h01, 3'd3, 7'h08, 7'h00);
        add(7'h01, 3'd3, 7'h08, 7'h77);
        add(7'h01, 3'd3, 7'h09, 7'h7F);
        add(7'h01, 3'd3, 7'h00, 7'h77);
        add(7'h01, 3'd3, 7'h00, 7'h00);
        // empty source set, parent S
        add(7'h00, 3'd4, 7'h00, 7'h10);
        add(7'h00, 3'd4, 7'h00, 7'h10);
        add(7'h00, 3'd4, 7'h10, 7'h10);
        add(7'h00, 3'd4, 7'h10, 7'h6F);
        add(7'h00, 3'd4, 7'h00, 7'h6F);
        add(7'h00, 3'd4, 7'h00, 7'h10);

        // power-on reset
        rst_n           = 1'b0;
        bar_if.data_i   = 7'h00;
        bar_if.src_r_i  = 7'h01;
        bar_if.dest_r_i = 3'd1;
        #1;
        check("por_async", 7'h00);
        repeat (2) @(posedge clk);
        #1;
        check("por_hold", 7'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // empty root with all inputs high: releases after one edge
        bar_if.data_i   = 7'h7F;
        bar_if.src_r_i  = 7'h00;
        bar_if.dest_r_i = 3'(root_dir(7));
        @(posedge clk);
        #1;
        check("pre_reset_set", 7'h7F);

        // mid-cycle asynchronous reset
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 7'h00);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_hold", 7'h00);
        end
        bar_if.data_i   = 7'h00;
        bar_if.src_r_i  = 7'h01;
        bar_if.dest_r_i = 3'd1;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            bar_if.src_r_i  = tv[i].src;
            bar_if.dest_r_i = tv[i].dest;
            bar_if.data_i   = tv[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tv[i].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run got stuck want finish");
        $fatal(1);
    end

endmodule
